// File: rtl/cm0_dap_cdc_capture_data.sv
// Receive end of a 32-bit toggle-handshake CDC channel: synchronise REQTOG, capture REGDI, hand it to the consumer, return ACKTOG.
// Optional parity check on the captured word is enabled by defining CM0_DAP_CDC_CAPTURE_PARITY_EN.
module cm0_dap_cdc_capture_data #(
  parameter int PRESENT     = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        REGCLK,
  input  logic        REGRESET,
  input  logic        REQTOG,
  input  logic [31:0] REGDI,
`ifdef CM0_DAP_CDC_CAPTURE_PARITY_EN
  input  logic        REGDIP,
  output logic        PARERR,
`endif
  input  logic        DATAREADY,
  output logic        DATAVALID,
  output logic [31:0] DATAO,
  output logic        ACKTOG,
  output logic        OVERRUN
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  // Out-of-range depths are clamped so the chain always has a legal 2..4 flops.
  localparam int SYNC_DEPTH = (SYNC_STAGES < 2) ? 2 : ((SYNC_STAGES > 4) ? 4 : SYNC_STAGES);

  // Flags a word whose launch parity is even (odd parity expected).
  function automatic logic parity_error(input logic par, input logic [31:0] data);
    parity_error = ~^{par, data};
  endfunction

  generate
    if (PRESENT != 0) begin : g_present
      logic [SYNC_DEPTH-1:0] reqsync;
      logic                  reqs;
      logic                  reqprev;
      logic                  reqedge;
      logic [0:0]            state;
      logic                  valid;
      logic [31:0]           data;
      logic                  ack;
      logic                  overrun;
      logic                  parerr;
      logic                  capture_perr;

`ifdef CM0_DAP_CDC_CAPTURE_PARITY_EN
      assign capture_perr = parity_error(REGDIP, REGDI);
`else
      assign capture_perr = 1'b0;
`endif

      // Request toggle synchroniser into REGCLK.
      always_ff @(posedge REGCLK) begin
        if (REGRESET) begin
          reqsync <= '0;
        end else begin
          reqsync <= {reqsync[SYNC_DEPTH-2:0], REQTOG};
        end
      end

      assign reqs    = reqsync[SYNC_DEPTH-1];
      assign reqedge = reqs ^ reqprev;

      // Capture/hold handshake; REGDI is only sampled on the IDLE->HOLD step.
      always_ff @(posedge REGCLK) begin
        if (REGRESET) begin
          state   <= IDLE;
          reqprev <= 1'b0;
          valid   <= 1'b0;
          data    <= 32'h0000_0000;
          ack     <= 1'b0;
          overrun <= 1'b0;
          parerr  <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              if (reqedge) begin
                data    <= REGDI;
                valid   <= 1'b1;
                reqprev <= reqs;
                parerr  <= capture_perr;
                state   <= HOLD;
              end else begin
                state <= IDLE;
              end
            end
            HOLD: begin
              // A new toggle while holding is left pending; it is taken after accept.
              if (reqedge) begin
                overrun <= 1'b1;
              end else begin
                overrun <= overrun;
              end
              if (DATAREADY) begin
                valid  <= 1'b0;
                ack    <= ~ack;
                parerr <= 1'b0;
                state  <= IDLE;
              end else begin
                state <= HOLD;
              end
            end
            default: begin
              valid  <= 1'b0;
              parerr <= 1'b0;
              state  <= IDLE;
            end
          endcase
        end
      end

      assign DATAVALID = valid;
      assign DATAO     = data;
      assign ACKTOG    = ack;
      assign OVERRUN   = overrun;
`ifdef CM0_DAP_CDC_CAPTURE_PARITY_EN
      assign PARERR    = parerr;
`else
      logic unused_parerr;
      assign unused_parerr = parerr;
`endif
    end else begin : g_absent
      logic unused_inputs;
`ifdef CM0_DAP_CDC_CAPTURE_PARITY_EN
      assign unused_inputs = ^{REGCLK, REGRESET, REQTOG, REGDI, DATAREADY, REGDIP};
      assign PARERR        = 1'b0;
`else
      assign unused_inputs = ^{REGCLK, REGRESET, REQTOG, REGDI, DATAREADY};
`endif
      assign DATAVALID = 1'b0;
      assign DATAO     = 32'h0000_0000;
      assign ACKTOG    = 1'b0;
      assign OVERRUN   = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_cm0_dap_cdc_capture_data.sv
// Bench for cm0_dap_cdc_capture_data: directed vector table plus randomized run against a reference model.
module tb_cm0_dap_cdc_capture_data;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst, req, rdy, dp;
  logic [31:0] di;
  logic        valid, ack, ovr, perr;
  logic [31:0] dout;
  int          vectors = 0;
  int          errors  = 0;

  always #5 clk = ~clk;

  cm0_dap_cdc_capture_data #(.PRESENT(1), .SYNC_STAGES(SYNC)) dut (
    .REGCLK(clk),
    .REGRESET(rst),
    .REQTOG(req),
    .REGDI(di),
`ifdef CM0_DAP_CDC_CAPTURE_PARITY_EN
    .REGDIP(dp),
    .PARERR(perr),
`endif
    .DATAREADY(rdy),
    .DATAVALID(valid),
    .DATAO(dout),
    .ACKTOG(ack),
    .OVERRUN(ovr)
  );
`ifndef CM0_DAP_CDC_CAPTURE_PARITY_EN
  assign perr = 1'b0;
`endif

  typedef struct {
    logic rst; logic req; logic [31:0] di; logic dp; logic rdy;
    logic ev; logic [31:0] ed; logic ea; logic eo; logic chkp; logic ep;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic r, input logic q, input logic [31:0] d, input logic p, input logic y,
                              input logic ev, input logic [31:0] ed, input logic ea, input logic eo,
                              input logic chkp = 1'b0, input logic ep = 1'b0);
    vec_t v;
    v.rst = r; v.req = q; v.di = d; v.dp = p; v.rdy = y;
    v.ev = ev; v.ed = ed; v.ea = ea; v.eo = eo; v.chkp = chkp; v.ep = ep;
    tbl.push_back(v);
  endfunction

  // Reference model: the request as seen SYNC edges after it was sampled, and the word/handshake rules.
  logic        hist[$];
  logic        m_hold, m_ack, m_ovr, m_taken, m_perr;
  logic [31:0] m_word;

  task automatic model_edge(input logic r, input logic q, input logic [31:0] d, input logic p, input logic y);
    logic vis;
    if (r) begin
      hist.delete();
      for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
      m_hold = 1'b0; m_word = 32'h0; m_ack = 1'b0; m_ovr = 1'b0; m_taken = 1'b0; m_perr = 1'b0;
    end else begin
      vis = hist.pop_front();
      hist.push_back(q);
      if (!m_hold) begin
        if (vis != m_taken) begin
          m_hold = 1'b1; m_word = d; m_taken = vis; m_perr = ~^{p, d};
        end
      end else begin
        if (vis != m_taken) m_ovr = 1'b1;
        if (y) begin
          m_hold = 1'b0; m_ack = ~m_ack; m_perr = 1'b0;
        end
      end
    end
  endtask

  task automatic apply(input logic r, input logic q, input logic [31:0] d, input logic p, input logic y);
    rst = r; req = q; di = d; dp = p; rdy = y;
    @(posedge clk);
    model_edge(r, q, d, p, y);
    #2;
  endtask

  task automatic check(input string name, input int idx, input logic ev, input logic [31:0] ed,
                       input logic ea, input logic eo, input logic chkp, input logic ep);
    logic bad;
    vectors++;
    bad = (valid !== ev) || (dout !== ed) || (ack !== ea) || (ovr !== eo);
`ifdef CM0_DAP_CDC_CAPTURE_PARITY_EN
    if (chkp && (perr !== ep)) bad = 1'b1;
`endif
    if (bad) begin
      errors++;
      $display("FAIL %s %0d: got valid=%0b data=%h ack=%0b ovr=%0b par=%0b, want valid=%0b data=%h ack=%0b ovr=%0b par=%0b",
               name, idx, valid, dout, ack, ovr, perr, ev, ed, ea, eo, ep);
    end
  endtask

  initial begin
    logic rq;
    logic y;
    logic [31:0] rd;
    logic rp;
    for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
    m_hold = 1'b0; m_word = 32'h0; m_ack = 1'b0; m_ovr = 1'b0; m_taken = 1'b0; m_perr = 1'b0;
    rst = 1'b1; req = 1'b0; di = 32'h0; dp = 1'b0; rdy = 1'b0;

    // Reset and idle
    add(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) add(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    // Single word with DATAREADY held high
    add(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    add(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    // Consumer stalls for 10 cycles
    add(1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) add(1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0);
    // Overrun: second toggle while holding A5A5A5A5
    add(1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
    add(1'b0, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b1);
    add(1'b0, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b1);
    add(1'b0, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b1, 1'b1, 32'h5A5A5A5A, 1'b1, 1'b1);
    add(1'b0, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b1, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b1);
    add(1'b0, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b1);
    // Reset while holding, then a fresh capture
    add(1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b1, 1'b1);
    add(1'b0, 1'b0, 32'h11112222, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 1'b1, 1'b1);
    add(1'b0, 1'b0, 32'h11112222, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 1'b1, 1'b1);
    add(1'b0, 1'b0, 32'h11112222, 1'b0, 1'b0, 1'b1, 32'h11112222, 1'b1, 1'b1);
    add(1'b1, 1'b0, 32'h11112222, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'h0F0F0F0F, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'h0F0F0F0F, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'h0F0F0F0F, 1'b0, 1'b1, 1'b1, 32'h0F0F0F0F, 1'b0, 1'b0);
    add(1'b0, 1'b1, 32'h0F0F0F0F, 1'b0, 1'b1, 1'b0, 32'h0F0F0F0F, 1'b1, 1'b0);
    // Accept and new edge on the same cycle
    add(1'b0, 1'b0, 32'h77777777, 1'b0, 1'b0, 1'b0, 32'h0F0F0F0F, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h77777777, 1'b0, 1'b0, 1'b0, 32'h0F0F0F0F, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h77777777, 1'b0, 1'b0, 1'b1, 32'h77777777, 1'b1, 1'b0);
    add(1'b0, 1'b1, 32'h88888888, 1'b0, 1'b0, 1'b1, 32'h77777777, 1'b1, 1'b0);
    add(1'b0, 1'b1, 32'h88888888, 1'b0, 1'b0, 1'b1, 32'h77777777, 1'b1, 1'b0);
    add(1'b0, 1'b1, 32'h88888888, 1'b0, 1'b1, 1'b0, 32'h77777777, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'h88888888, 1'b0, 1'b0, 1'b1, 32'h88888888, 1'b0, 1'b1);
    add(1'b0, 1'b1, 32'h88888888, 1'b0, 1'b1, 1'b0, 32'h88888888, 1'b1, 1'b1);
    // Parity: one set bit with REGDIP=0 is odd (no error), REGDIP=1 is even (error)
    add(1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h88888888, 1'b1, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h88888888, 1'b1, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h00000001, 1'b1, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 32'h00000001, 1'b0, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b1, 1'b1, 1'b1);
    add(1'b0, 1'b1, 32'h00000001, 1'b1, 1'b1, 1'b0, 32'h00000001, 1'b1, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].req, tbl[i].di, tbl[i].dp, tbl[i].rdy);
      check("table", i, tbl[i].ev, tbl[i].ed, tbl[i].ea, tbl[i].eo, tbl[i].chkp, tbl[i].ep);
    end

    // Randomized traffic, including overruns, occasional resets and a DATAREADY-always-high phase
    rq = req;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) rq = ~rq;
      rd = $urandom;
      rp = 1'($urandom_range(0, 1));
      if (c < 1000)      y = 1'($urandom_range(0, 1));
      else if (c < 2000) y = 1'b1;
      else               y = ($urandom_range(0, 3) == 0);
      apply(($urandom_range(0, 299) == 0), rq, rd, rp, y);
      check("random", c, m_hold, m_word, m_ack, m_ovr, 1'b1, m_perr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
